// File: rtl/tx_arbiter_pkg.sv
// rtl/tx_arbiter_pkg.sv - shared constants, FSM state codes and index-width helper for tx_arbiter
package tx_arbiter_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int DATA_W_DEF  = 7;
    localparam int TIMEOUT_DEF = 64;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // Width of a requester index; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// rtl/tx_arbiter_rr_pick.sv - combinational round-robin picker starting at ptr
module rr_pick
    import tx_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    // Walk from farthest to nearest so the first set bit at or after ptr wins
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k >= N_REQ) ? IDX_W'(int'(ptr) + k - N_REQ)
                                           : IDX_W'(int'(ptr) + k);
            if (req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin transmit arbiter in front of a serial sender; watchdog under TX_ARBITER_TIMEOUT_EN
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] reqData,
    output logic [N_REQ-1:0]        done,
    output logic                    busy,
    output logic                    txStart,
    output logic [DATA_W-1:0]       txData,
    input  logic                    txSent,
    output logic                    err
);

    localparam int IDX_W = idx_width(N_REQ);

    logic [1:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  next_ptr;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [DATA_W-1:0] pick_data;
    logic              timeout_hit;
    logic              watchdog_fire;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign next_ptr = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);

    // Select the candidate winner's character from the packed request bus
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_data = reqData[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef TX_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;

    assign in_wait = (state == ST_WAIT_ACK) || (state == ST_WAIT_DONE);

    // Count cycles spent waiting on the sender; restarts with every new grant
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wait_cnt <= '0;
        end else if (state == ST_IDLE && pick_valid) begin
            wait_cnt <= '0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Fires in the cycle whose increment would bring the count to TIMEOUT
    assign timeout_hit = in_wait && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // A zero TIMEOUT leaves the watchdog inert even when it is built in
    assign watchdog_fire = timeout_hit && (TIMEOUT != 0);

    // Grant, strobe, handshake with the sender and retire the frame
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            winner <= '0;
            txData <= '0;
            done   <= '0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        winner <= pick_idx;
                        txData <= pick_data;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (watchdog_fire) begin
                        ptr   <= next_ptr;
                        state <= ST_IDLE;
                    end else if (!txSent) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (watchdog_fire) begin
                        ptr   <= next_ptr;
                        state <= ST_IDLE;
                    end else if (txSent) begin
                        done  <= N_REQ'(1) << winner;
                        ptr   <= next_ptr;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != ST_IDLE);
    assign txStart = (state == ST_ISSUE);
    assign err     = watchdog_fire;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - self-checking bench for tx_arbiter; timeout sequence under TX_ARBITER_TIMEOUT_EN
module tb_tx_arbiter;

    localparam int N = 4;
    localparam int W = 7;

    logic           clk = 1'b0;
    logic           rstN;
    logic [N-1:0]   req;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   done;
    logic           busy;
    logic           txStart;
    logic [W-1:0]   txData;
    logic           txSent;
    logic           err;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] data;
        logic [N-1:0]   exp_done;
        logic [W-1:0]   exp_tx;
    } vec_t;

    vec_t vecs [6];

    logic [W-1:0] got_tx;
    logic [N-1:0] got_done;

    int           model_ptr;
    int           exp_win;
    int           snd_state;
    int           snd_delay;
    int           snd_cnt;
    int           frames;
    bit           active;
    bit           done_due;
    bit           exp_start;
    logic [W-1:0] exp_data;
    logic [N-1:0] exp_done;

    tx_arbiter #(
        .N_REQ   (N),
        .DATA_W  (W),
        .TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .rstN    (rstN),
        .req     (req),
        .reqData (reqData),
        .done    (done),
        .busy    (busy),
        .txStart (txStart),
        .txData  (txData),
        .txSent  (txSent),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            if (n_errs <= 40) begin
                $display("FAIL %s: got %0h expected %0h", name, got, exp);
            end
        end
    endtask

    function automatic logic [W-1:0] slice_of(input logic [N*W-1:0] d, input int i);
        return d[i*W +: W];
    endfunction

    function automatic int rr_ref(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic do_reset();
        rstN    = 1'b0;
        req     = '0;
        reqData = '0;
        txSent  = 1'b1;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic wait_start();
        int waited;
        waited = 0;
        @(negedge clk);
        chk("no_stray_done", 32'(done), 32'(0));
        while (!txStart && waited < 20) begin
            @(negedge clk);
            chk("no_stray_done", 32'(done), 32'(0));
            waited++;
        end
        chk("start_seen", 32'(txStart), 32'(1));
    endtask

    task automatic do_frame(output logic [W-1:0] ftx, output logic [N-1:0] fdone);
        logic [N*W-1:0] saved;
        ftx   = '0;
        fdone = '0;
        wait_start();
        if (txStart !== 1'b1) return;
        ftx     = txData;
        saved   = reqData;
        reqData = ~reqData;
        txSent  = 1'b0;
        @(negedge clk);
        chk("strobe_single", 32'(txStart), 32'(0));
        chk("busy_in_frame", 32'(busy), 32'(1));
        @(negedge clk);
        chk("data_hold", 32'(txData), 32'(ftx));
        txSent = 1'b1;
        @(negedge clk);
        fdone = done;
        chk("busy_after_done", 32'(busy), 32'(0));
        reqData = saved;
    endtask

    initial begin
        vecs[0] = '{4'b0100, {7'h11, 7'h55, 7'h22, 7'h33}, 4'b0100, 7'h55};
        vecs[1] = '{4'b1001, {7'h7f, 7'h00, 7'h00, 7'h01}, 4'b0001, 7'h01};
        vecs[2] = '{4'b1110, {7'h0a, 7'h0b, 7'h0c, 7'h0d}, 4'b0010, 7'h0c};
        vecs[3] = '{4'b1000, {7'h2a, 7'h01, 7'h02, 7'h03}, 4'b1000, 7'h2a};
        vecs[4] = '{4'b1111, {7'h40, 7'h30, 7'h20, 7'h10}, 4'b0001, 7'h10};
        vecs[5] = '{4'b0010, {7'h00, 7'h00, 7'h7e, 7'h00}, 4'b0010, 7'h7e};

        // Reset holds everything quiet even with requests pending
        rstN    = 1'b0;
        req     = 4'b1111;
        reqData = {7'h01, 7'h02, 7'h03, 7'h04};
        txSent  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_txStart", 32'(txStart), 32'(0));
            chk("rst_txData", 32'(txData), 32'(0));
            chk("rst_done", 32'(done), 32'(0));
            chk("rst_err", 32'(err), 32'(0));
        end

        // Single-frame vectors, each from a fresh reset (ptr = 0)
        for (int v = 0; v < 6; v++) begin
            do_reset();
            reqData = vecs[v].data;
            req     = vecs[v].req;
            do_frame(got_tx, got_done);
            chk($sformatf("vec%0d_txData", v), 32'(got_tx), 32'(vecs[v].exp_tx));
            chk($sformatf("vec%0d_done", v), 32'(got_done), 32'(vecs[v].exp_done));
            req = '0;
        end

        // Simultaneous requests 0 and 3: 0 first, then 3
        do_reset();
        reqData = {7'h31, 7'h00, 7'h00, 7'h13};
        req     = 4'b1001;
        do_frame(got_tx, got_done);
        chk("simul_first_done", 32'(got_done), 32'(4'b0001));
        chk("simul_first_data", 32'(got_tx), 32'(7'h13));
        req = 4'b1000;
        do_frame(got_tx, got_done);
        chk("simul_second_done", 32'(got_done), 32'(4'b1000));
        chk("simul_second_data", 32'(got_tx), 32'(7'h31));
        req = '0;

        // Fairness with all requests held
        do_reset();
        reqData = {7'h04, 7'h03, 7'h02, 7'h01};
        req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            do_frame(got_tx, got_done);
            chk($sformatf("fair%0d_done", k), 32'(got_done), 32'(4'b0001 << (k % 4)));
            chk($sformatf("fair%0d_data", k), 32'(got_tx), 32'((k % 4) + 1));
        end
        req = '0;

        // Reset in WAIT_DONE after ptr has moved away from 0
        do_reset();
        reqData = {7'h01, 7'h5a, 7'h3c, 7'h11};
        req     = 4'b0010;
        do_frame(got_tx, got_done);
        chk("pre_rst_done", 32'(got_done), 32'(4'b0010));
        req = 4'b0100;
        wait_start();
        txSent = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'(1));
        chk("pre_rst_txData", 32'(txData), 32'(7'h5a));
        #2;
        rstN   = 1'b0;
        txSent = 1'b1;
        req    = '0;
        #1;
        chk("midrst_txStart", 32'(txStart), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_txData", 32'(txData), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_err", 32'(err), 32'(0));
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(done), 32'(0));
            chk("post_rst_idle", 32'(busy), 32'(0));
        end
        reqData = {7'h44, 7'h33, 7'h22, 7'h66};
        req     = 4'b1111;
        do_frame(got_tx, got_done);
        chk("post_rst_grant_done", 32'(got_done), 32'(4'b0001));
        chk("post_rst_grant_data", 32'(got_tx), 32'(7'h66));
        req = '0;

`ifdef TX_ARBITER_TIMEOUT_EN
        // Sender never drops txSent: watchdog expires, ptr moves past the winner
        do_reset();
        reqData = {7'h00, 7'h00, 7'h2b, 7'h1a};
        req     = 4'b0011;
        wait_start();
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk($sformatf("to_done_%0d", k), 32'(done), 32'(0));
            chk($sformatf("to_err_%0d", k), 32'(err), 32'(k == 16));
            chk($sformatf("to_busy_%0d", k), 32'(busy), 32'(k <= 16));
        end
        do_frame(got_tx, got_done);
        chk("to_next_data", 32'(got_tx), 32'(7'h2b));
        chk("to_next_done", 32'(got_done), 32'(4'b0010));
        req = '0;
`endif

        // Random traffic against a transaction-level reference
        do_reset();
        model_ptr = 0;
        exp_win   = 0;
        exp_data  = '0;
        active    = 1'b0;
        done_due  = 1'b0;
        snd_state = 0;
        snd_delay = 0;
        snd_cnt   = 0;
        frames    = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_start = !active && (req != '0);
            chk("rand_txStart", 32'(txStart), 32'(exp_start));
            if (exp_start) begin
                exp_win   = rr_ref(req, model_ptr);
                exp_data  = slice_of(reqData, exp_win);
                active    = 1'b1;
                snd_state = 1;
                snd_delay = $urandom_range(0, 3);
                snd_cnt   = $urandom_range(2, 6);
            end
            exp_done = done_due ? (N'(1) << exp_win) : '0;
            chk("rand_done", 32'(done), 32'(exp_done));
            if (done_due) begin
                active    = 1'b0;
                done_due  = 1'b0;
                model_ptr = (exp_win + 1) % N;
                frames++;
            end
            chk("rand_busy", 32'(busy), 32'(active));
            if (active) chk("rand_txData", 32'(txData), 32'(exp_data));
            chk("rand_err", 32'(err), 32'(0));

            if (snd_state == 1) begin
                if (snd_delay == 0) begin
                    txSent    = 1'b0;
                    snd_state = 2;
                end else begin
                    snd_delay--;
                end
            end else if (snd_state == 2) begin
                snd_cnt--;
                if (snd_cnt == 0) begin
                    txSent    = 1'b1;
                    snd_state = 0;
                    done_due  = 1'b1;
                end
            end

            for (int i = 0; i < N; i++) begin
                if (exp_done[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else reqData[i*W +: W] = W'($urandom);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i]             = 1'b1;
                        reqData[i*W +: W]  = W'($urandom);
                    end
                end else if (active && i == exp_win) begin
                    reqData[i*W +: W] = W'($urandom);
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end
            end
        end
        chk("rand_frames", 32'(frames > 100), 32'(1));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
